// File: rtl/token_pipe_ldst_mc_pkg.sv
// Shared types for the multi-channel load/store token pipe.
package token_pipe_ldst_mc_pkg;

  typedef logic [31:0] address_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] tag;
  } pipe_exe_tmp_t;

  typedef enum logic {
    LdstIdle,
    LdstReq
  } ldst_fsm_t;

endpackage

// File: rtl/token_pipe_ldst_mc_ring.sv
// Ring-buffer pointer/occupancy control for one channel FIFO.
module token_pipe_ldst_mc_ring #(
  parameter int unsigned DEPTH_BUFF = 8,
  parameter int unsigned WIDTH_BUFF = $clog2(DEPTH_BUFF),
  parameter int unsigned TH_STALL   = DEPTH_BUFF - 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  output logic                  wr_ok,
  output logic [WIDTH_BUFF-1:0] wptr,
  output logic [WIDTH_BUFF-1:0] rptr,
  output logic                  empty,
  output logic                  full,
  output logic                  stall
);

  localparam logic [WIDTH_BUFF:0] Depth   = (WIDTH_BUFF + 1)'(DEPTH_BUFF);
  localparam logic [WIDTH_BUFF:0] ThStall = (WIDTH_BUFF + 1)'(TH_STALL);

  logic [WIDTH_BUFF-1:0] wptr_q, rptr_q;
  logic [WIDTH_BUFF:0]   cnt_q;
  logic                  rd_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == Depth);
  assign stall = (cnt_q >= ThStall);
  // Full is judged before any same-cycle pop, so a write into a full FIFO is dropped.
  assign wr_ok = we & ~full;
  assign rd_ok = re & ~empty;
  assign wptr  = wptr_q;
  assign rptr  = rptr_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) rptr_q <= rptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/token_pipe_ldst_mc.sv
// Per-channel descriptor FIFOs arbitrated round-robin onto one DMem request port;
// zero-length heads retire locally without a request.
module token_pipe_ldst_mc
  import token_pipe_ldst_mc_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DEPTH_BUFF = 8,
  parameter int unsigned WIDTH_BUFF = $clog2(DEPTH_BUFF),
  parameter int unsigned WIDTH_CH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned TH_STALL   = DEPTH_BUFF - 2,
  parameter type         TYPE       = pipe_exe_tmp_t
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Stall,
  input  logic                  I_Access_Grant,
  input  logic [NUM_CH-1:0]     I_Req,
  input  address_t [NUM_CH-1:0] I_Length,
  input  address_t [NUM_CH-1:0] I_Stride,
  input  address_t [NUM_CH-1:0] I_Base,
  input  TYPE [NUM_CH-1:0]      I_Token,
  output logic                  O_Req,
  output logic [WIDTH_CH-1:0]   O_Ch,
  output address_t              O_Length,
  output address_t              O_Stride,
  output address_t              O_Base,
  output TYPE                   O_Token,
  output logic [NUM_CH-1:0]     O_Stall,
  output logic [NUM_CH-1:0]     O_Empty,
  output logic [NUM_CH-1:0]     O_Full,
  output logic [NUM_CH-1:0]     O_Ovf
);

  localparam logic [WIDTH_CH:0] NumChW = (WIDTH_CH + 1)'(NUM_CH);

  ldst_fsm_t             state_q, state_d;
  logic [WIDTH_CH-1:0]   sel_q, sel_d, rr_q, rr_d, pick;
  logic [NUM_CH-1:0]     ovf_q, wr_ok, pop, zero_pop, eligible;
  logic                  grant_pop, found;
  logic [WIDTH_BUFF-1:0] wptr [NUM_CH];
  logic [WIDTH_BUFF-1:0] rptr [NUM_CH];
  address_t              head_len [NUM_CH];

  address_t len_mem    [NUM_CH][DEPTH_BUFF];
  address_t stride_mem [NUM_CH][DEPTH_BUFF];
  address_t base_mem   [NUM_CH][DEPTH_BUFF];
  TYPE      tok_mem    [NUM_CH][DEPTH_BUFF];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    token_pipe_ldst_mc_ring #(
      .DEPTH_BUFF(DEPTH_BUFF),
      .WIDTH_BUFF(WIDTH_BUFF),
      .TH_STALL  (TH_STALL)
    ) u_ring (
      .clock(clock),
      .reset(reset),
      .we   (I_Req[c]),
      .re   (pop[c]),
      .wr_ok(wr_ok[c]),
      .wptr (wptr[c]),
      .rptr (rptr[c]),
      .empty(O_Empty[c]),
      .full (O_Full[c]),
      .stall(O_Stall[c])
    );

    assign head_len[c] = len_mem[c][rptr[c]];
    assign eligible[c] = ~O_Empty[c] & (head_len[c] != '0);
    // The locked channel's head is never zero-length, but guard it so it can't be popped twice.
    assign zero_pop[c] = ~O_Empty[c] & (head_len[c] == '0) &
                         ~((state_q == LdstReq) & (sel_q == WIDTH_CH'(c)));
    assign pop[c]      = zero_pop[c] | (grant_pop & (sel_q == WIDTH_CH'(c)));
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ok[c]) begin
        len_mem[c][wptr[c]]    <= I_Length[c];
        stride_mem[c][wptr[c]] <= I_Stride[c];
        base_mem[c][wptr[c]]   <= I_Base[c];
        tok_mem[c][wptr[c]]    <= I_Token[c];
      end
    end
  end

  always_comb begin
    logic [WIDTH_CH:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, rr_q} + (WIDTH_CH + 1)'(i);
      if (idx >= NumChW) idx = idx - NumChW;
      if (!found && eligible[idx[WIDTH_CH-1:0]]) begin
        found = 1'b1;
        pick  = idx[WIDTH_CH-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    grant_pop = 1'b0;
    unique case (state_q)
      LdstIdle: begin
        if (found) begin
          sel_d   = pick;
          state_d = LdstReq;
        end
      end
      LdstReq: begin
        if (I_Access_Grant && !I_Stall) begin
          grant_pop = 1'b1;
          rr_d      = (sel_q == WIDTH_CH'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
          state_d   = LdstIdle;
        end
      end
      default: state_d = LdstIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= LdstIdle;
      sel_q   <= '0;
      rr_q    <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_q | (I_Req & O_Full);
    end
  end

  assign O_Ovf = ovf_q;
  assign O_Req = (state_q == LdstReq) & ~I_Stall;

  always_comb begin
    O_Ch     = '0;
    O_Length = '0;
    O_Stride = '0;
    O_Base   = '0;
    O_Token  = '0;
    if (O_Req) begin
      O_Ch     = sel_q;
      O_Length = len_mem[sel_q][rptr[sel_q]];
      O_Stride = stride_mem[sel_q][rptr[sel_q]];
      O_Base   = base_mem[sel_q][rptr[sel_q]];
      O_Token  = tok_mem[sel_q][rptr[sel_q]];
    end
  end

endmodule
